// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
//
// Shared definitions for the SIMD dispatch slice:
//   - opcode encoding of the 16-bit instruction word
//   - bit positions of the opcode / rd / rs1 / rs2 fields
//   - dispatcher state encoding
//   - small decode helper used by the dispatcher
//
// Instruction word layout:
//   [15:14] opcode   [13:11] rd   [10:8] rs1   [7:5] rs2   [4:0] ignored
// -----------------------------------------------------------------------------
package simd_pkg;

    localparam int INSTR_W   = 16;
    localparam int REG_IDX_W = 3;
    localparam int OPC_W     = 2;

    // Least-significant bit of each instruction field.
    localparam int OPC_LSB = 14;
    localparam int RD_LSB  = 11;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_RSVD = 2'b10,
        OP_NOP  = 2'b11
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } dispatch_state_t;

    // Only ADD and MUL produce a result worth keeping; the reserved
    // opcode behaves exactly like NOP.
    function automatic logic writes_back(input opcode_t op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/simd_vreg_file.sv
// -----------------------------------------------------------------------------
// simd_vreg_file
//
// NUM_REGS x (32*LANES)-bit vector register file, all entries cleared on reset.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   wb_en/wb_addr/wb_data  retirement write port (wins over the host port)
//   host_en/host_addr/host_data  host preload write port
//   rd_addr_a/rd_data_a    operand read port A, bypasses the same-cycle write
//   rd_addr_b/rd_data_b    operand read port B, bypasses the same-cycle write
//   dbg_addr/dbg_data      debug read port, raw storage (no bypass)
// -----------------------------------------------------------------------------
module simd_vreg_file
    import simd_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int NUM_REGS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_en,
    input  logic [REG_IDX_W-1:0]   wb_addr,
    input  logic [32*LANES-1:0]    wb_data,
    input  logic                   host_en,
    input  logic [REG_IDX_W-1:0]   host_addr,
    input  logic [32*LANES-1:0]    host_data,
    input  logic [REG_IDX_W-1:0]   rd_addr_a,
    output logic [32*LANES-1:0]    rd_data_a,
    input  logic [REG_IDX_W-1:0]   rd_addr_b,
    output logic [32*LANES-1:0]    rd_data_b,
    input  logic [REG_IDX_W-1:0]   dbg_addr,
    output logic [32*LANES-1:0]    dbg_data
);

    localparam int W = 32 * LANES;

    logic [W-1:0]           regs [NUM_REGS];
    logic                   wr_en;
    logic [REG_IDX_W-1:0]   wr_addr;
    logic [W-1:0]           wr_data;

    // Writeback and host writes are mutually exclusive by construction
    // (host writes only land in IDLE, writeback only in EXEC); the priority
    // just makes the mux well defined.
    always_comb begin
        wr_en   = wb_en | host_en;
        wr_addr = wb_en ? wb_addr : host_addr;
        wr_data = wb_en ? wb_data : host_data;
    end

    // NOTE: the storage array is reset element by element because software
    // relies on every register reading 0 after reset; this is a flop array,
    // not a RAM macro, so a reset is legal here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking assignment keeps every flop updating from
            // pre-edge values, so readers in other processes never race.
            regs[wr_addr] <= wr_data;
        end
    end

    // Operand ports see a write landing on the same edge, so a host preload
    // that coincides with an instruction accept feeds the new value.
    assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];

    // Debug view shows committed state only.
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/simd_dispatch_unit.sv
// -----------------------------------------------------------------------------
// simd_dispatch_unit
//
// Issue stage in front of simd_gpu_core. Accepts one instruction at a time,
// reads its two vector operands, holds them stable on the core inputs for
// ALU_LATENCY+1 cycles, then writes core_result back to rd and pulses retire.
//
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   instr_valid/instr_ready/instr  upstream instruction handshake
//   wr_en/wr_addr/wr_data        host preload (honoured only while IDLE)
//   dbg_addr/dbg_data            combinational register read-back
//   core_instruction, core_src_a, core_src_b   held inputs to the core
//   core_result                  core output, captured at retirement
//   busy                         instruction in flight
//   retire_valid/retire_rd       one-cycle retirement pulse and its rd
//
// ALU_LATENCY must lie in 0..15 (4-bit latency counter).
// -----------------------------------------------------------------------------
module simd_dispatch_unit
    import simd_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int NUM_REGS    = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_W-1:0]     instr,
    input  logic                   wr_en,
    input  logic [REG_IDX_W-1:0]   wr_addr,
    input  logic [32*LANES-1:0]    wr_data,
    input  logic [REG_IDX_W-1:0]   dbg_addr,
    output logic [32*LANES-1:0]    dbg_data,
    output logic [INSTR_W-1:0]     core_instruction,
    output logic [32*LANES-1:0]    core_src_a,
    output logic [32*LANES-1:0]    core_src_b,
    input  logic [32*LANES-1:0]    core_result,
    output logic                   busy,
    output logic                   retire_valid,
    output logic [REG_IDX_W-1:0]   retire_rd
);

    localparam int W = 32 * LANES;

    dispatch_state_t        state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   accept;
    logic                   retire;
    logic                   host_en;
    logic                   wb_en;
    logic [W-1:0]           rf_src_a;
    logic [W-1:0]           rf_src_b;
    logic [REG_IDX_W-1:0]   cur_rd;
    opcode_t                cur_op;

    // Fields of the in-flight instruction come from the held copy, so they
    // stay valid for the whole EXEC window.
    assign cur_rd = core_instruction[RD_LSB +: REG_IDX_W];
    assign cur_op = opcode_t'(core_instruction[OPC_LSB +: OPC_W]);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gating with reset keeps ready low while reset is held.
                instr_ready = reset;
                accept      = instr_valid && reset;
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = 4'(ALU_LATENCY);
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    // An instruction caught by reset in its last cycle is
                    // aborted, so the pulse is suppressed as well.
                    retire  = reset;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign retire_valid = retire;
    assign retire_rd    = retire ? cur_rd : '0;
    assign host_en      = wr_en && (state_q == IDLE);
    assign wb_en        = retire && writes_back(cur_op);

    // ------------------------------------------------------------------
    // State register and held core inputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            core_instruction <= '0;
            core_src_a       <= '0;
            core_src_b       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                core_instruction <= instr;
                core_src_a       <= rf_src_a;
                core_src_b       <= rf_src_b;
            end
        end
    end

    simd_vreg_file #(
        .LANES    (LANES),
        .NUM_REGS (NUM_REGS)
    ) u_vreg_file (
        .clk       (clk),
        .reset     (reset),
        .wb_en     (wb_en),
        .wb_addr   (cur_rd),
        .wb_data   (core_result),
        .host_en   (host_en),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .rd_addr_a (instr[RS1_LSB +: REG_IDX_W]),
        .rd_data_a (rf_src_a),
        .rd_addr_b (instr[RS2_LSB +: REG_IDX_W]),
        .rd_data_b (rf_src_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

endmodule
